// File: rtl/vgg16_pkg.sv
// Shared definitions for the pooling controller: FSM state encoding and geometry helpers.
package vgg16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

  function automatic int calc_npix(input int image_width);
    return image_width * image_width;
  endfunction

  function automatic int calc_nout(input int image_width);
    return (image_width / 2) * (image_width / 2);
  endfunction

  // Address width for n entries, never narrower than one bit.
  function automatic int calc_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_pooling2x2_ctrl_if.sv
// Bus bundle between the pooling controller and its sequencer, memories and pooling array.
interface max_pooling2x2_ctrl_if
  import vgg16_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IMAGE_WIDTH      = 4,
  parameter int NUMBER_OF_KERNEL = 8
) ();
  localparam int PIX_AW = calc_aw(calc_npix(IMAGE_WIDTH));
  localparam int OUT_AW = calc_aw(calc_nout(IMAGE_WIDTH));
  localparam int BUS_W  = NUMBER_OF_KERNEL * DATA_WIDTH;

  logic                        i_start;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_rd_en;
  logic [PIX_AW-1:0]           o_rd_addr;
  logic [BUS_W-1:0]            i_rd_data;
  logic                        o_pool_start;
  logic                        o_pool_valid;
  logic [BUS_W-1:0]            o_pool_data;
  logic [NUMBER_OF_KERNEL-1:0] i_pool_valid;
  logic [BUS_W-1:0]            i_pool_data;
  logic                        o_wr_en;
  logic [OUT_AW-1:0]           o_wr_addr;
  logic [BUS_W-1:0]            o_wr_data;
  logic                        o_err;

  modport slave (
    input  i_start, i_rd_data, i_pool_valid, i_pool_data,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_pool_start, o_pool_valid,
    output o_pool_data, o_wr_en, o_wr_addr, o_wr_data, o_err
  );

  modport master (
    output i_start, i_rd_data, i_pool_valid, i_pool_data,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_pool_start, o_pool_valid,
    input  o_pool_data, o_wr_en, o_wr_addr, o_wr_data, o_err
  );

endinterface

// File: rtl/maxp_result_collector.sv
// Collects pooled results into the output bank; optional lane check under MAXP_CTRL_LANE_CHECK_EN.
module maxp_result_collector
  import vgg16_pkg::*;
#(
  parameter int  DATA_WIDTH       = 32,
  parameter int  IMAGE_WIDTH      = 4,
  parameter int  NUMBER_OF_KERNEL = 8,
  localparam int OUT_AW           = calc_aw(calc_nout(IMAGE_WIDTH)),
  localparam int BUS_W            = NUMBER_OF_KERNEL * DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        active_i,
  input  logic [NUMBER_OF_KERNEL-1:0] pool_valid_i,
  input  logic [BUS_W-1:0]            pool_data_i,
  output logic                        wr_en_o,
  output logic [OUT_AW-1:0]           wr_addr_o,
  output logic [BUS_W-1:0]            wr_data_o,
  output logic                        full_o,
  output logic                        err_o
);
  localparam int NOUT  = calc_nout(IMAGE_WIDTH);
  localparam int CNT_W = OUT_AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NOUT);

  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              wr_en_q;
  logic [OUT_AW-1:0] wr_addr_q;
  logic [BUS_W-1:0]  wr_data_q;
  logic              err_q, err_d;
  logic              accept_s;

  // Accept only when every lane agrees and the output bank is not yet full.
  always_comb begin
    accept_s  = 1'b0;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    if (active_i && (&pool_valid_i) && (out_cnt_q < CNT_MAX)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (clear_i) begin
      out_cnt_d = '0;
    end else if (accept_s) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end
`ifdef MAXP_CTRL_LANE_CHECK_EN
    if (clear_i) begin
      err_d = 1'b0;
    end else if ((|pool_valid_i) && !(&pool_valid_i)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
`else
    err_d = 1'b0;
`endif
  end

  // Write-port and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      out_cnt_q <= out_cnt_d;
      wr_en_q   <= accept_s;
      err_q     <= err_d;
      if (accept_s) begin
        wr_addr_q <= out_cnt_q[OUT_AW-1:0];
        wr_data_q <= pool_data_i;
      end else begin
        wr_addr_q <= wr_addr_q;
        wr_data_q <= wr_data_q;
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign full_o    = (out_cnt_q == CNT_MAX);
  assign err_o     = err_q;

endmodule

// File: rtl/max_pooling2x2_ctrl.sv
// Sequences one 2x2 max-pooling pass: raster feed, result collection, done pulse.
// Optional lane-mismatch flag enabled by MAXP_CTRL_LANE_CHECK_EN (inside the collector).
module max_pooling2x2_ctrl
  import vgg16_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IMAGE_WIDTH      = 4,
  parameter int NUMBER_OF_KERNEL = 8
) (
  input logic                  clk,
  input logic                  rst,
  max_pooling2x2_ctrl_if.slave bus
);
  localparam int NPIX   = calc_npix(IMAGE_WIDTH);
  localparam int PIX_AW = calc_aw(NPIX);
  localparam int BUS_W  = NUMBER_OF_KERNEL * DATA_WIDTH;
  localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(NPIX - 1);

  pool_state_e       state_q, state_d;
  logic [PIX_AW-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q;
  logic              feed_vld_q;
  logic              pool_valid_q;
  logic [BUS_W-1:0]  pool_data_q;
  logic              pool_start_q;
  logic              busy_q;
  logic              done_q;
  logic              start_acc_s;
  logic              out_full_s;
  logic              active_s;

  assign active_s = (state_q != ST_IDLE);

  // Next-state logic; i_start only matters in IDLE, so it is never queued.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    start_acc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d     = ST_FEED;
          rd_addr_d   = '0;
          start_acc_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (rd_addr_q == PIX_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + PIX_AW'(1);
        end
      end
      ST_DRAIN: begin
        if (!feed_vld_q && !pool_valid_q && out_full_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, feed pipe and registered control outputs (derived from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      feed_vld_q   <= 1'b0;
      pool_valid_q <= 1'b0;
      pool_data_q  <= '0;
      pool_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= (state_d == ST_FEED);
      feed_vld_q   <= rd_en_q;
      pool_valid_q <= feed_vld_q;
      pool_data_q  <= bus.i_rd_data;
      pool_start_q <= start_acc_s;
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  maxp_result_collector #(
    .DATA_WIDTH      (DATA_WIDTH),
    .IMAGE_WIDTH     (IMAGE_WIDTH),
    .NUMBER_OF_KERNEL(NUMBER_OF_KERNEL)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_acc_s),
    .active_i    (active_s),
    .pool_valid_i(bus.i_pool_valid),
    .pool_data_i (bus.i_pool_data),
    .wr_en_o     (bus.o_wr_en),
    .wr_addr_o   (bus.o_wr_addr),
    .wr_data_o   (bus.o_wr_data),
    .full_o      (out_full_s),
    .err_o       (bus.o_err)
  );

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_rd_en      = rd_en_q;
  assign bus.o_rd_addr    = rd_addr_q;
  assign bus.o_pool_start = pool_start_q;
  assign bus.o_pool_valid = pool_valid_q;
  assign bus.o_pool_data  = pool_data_q;

endmodule

// File: tb/tb_max_pooling2x2_ctrl.sv
// Self-checking bench for max_pooling2x2_ctrl with a behavioural input bank and pooling array.
module tb_max_pooling2x2_ctrl;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int K  = 2;
`ifdef MAXP_CTRL_LANE_CHECK_EN
  localparam logic [63:0] EXP_ERR = 64'd1;
`else
  localparam logic [63:0] EXP_ERR = 64'd0;
`endif

  typedef struct {
    int delay;
    int extra;
    int exp_done_rel;
    int exp_last_wr_rel;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  max_pooling2x2_ctrl_if #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .NUMBER_OF_KERNEL(K)) bus ();

  max_pooling2x2_ctrl #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .NUMBER_OF_KERNEL(K)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Input bank: lane k of pixel p holds p*2+k, one cycle read latency.
  logic [31:0] a32;
  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      a32 = {28'd0, bus.o_rd_addr};
      bus.i_rd_data <= {a32 * 32'd2 + 32'd1, a32 * 32'd2};
    end
  end

  // Behavioural pooling array with configurable latency and surplus results.
  int          model_delay = 0;
  int          model_extra = 0;
  bit          force_partial = 1'b0;
  int          pcnt = 0;
  logic [63:0] pix [IW*IW];
  logic [63:0] rq_d [$];
  int          rq_t [$];

  function automatic logic [63:0] win_max(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] d);
    logic [63:0] r;
    logic [31:0] m;
    r = '0;
    for (int k = 0; k < K; k++) begin
      m = a[k*32 +: 32];
      if (b[k*32 +: 32] > m) m = b[k*32 +: 32];
      if (c[k*32 +: 32] > m) m = c[k*32 +: 32];
      if (d[k*32 +: 32] > m) m = d[k*32 +: 32];
      r[k*32 +: 32] = m;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pcnt = 0;
      rq_d.delete();
      rq_t.delete();
      bus.i_pool_valid <= 2'b00;
      bus.i_pool_data  <= 64'd0;
    end else begin
      if (bus.o_pool_start) pcnt = 0;
      if (bus.o_pool_valid && pcnt < IW*IW) begin
        pix[pcnt] = bus.o_pool_data;
        if ((pcnt % 2 == 1) && ((pcnt / IW) % 2 == 1)) begin
          rq_d.push_back(win_max(pix[pcnt], pix[pcnt-1], pix[pcnt-IW], pix[pcnt-IW-1]));
          rq_t.push_back(cyc + model_delay);
          if (pcnt == IW*IW-1) begin
            for (int e = 0; e < model_extra; e++) begin
              rq_d.push_back(64'h0000_0BAD_0000_0BAD);
              rq_t.push_back(cyc + model_delay);
            end
          end
        end
        pcnt++;
      end
      if (force_partial) begin
        bus.i_pool_valid <= 2'b01;
        bus.i_pool_data  <= 64'h0000_DEAD_0000_DEAD;
        force_partial = 1'b0;
      end else if (rq_t.size() > 0 && rq_t[0] <= cyc) begin
        bus.i_pool_valid <= 2'b11;
        bus.i_pool_data  <= rq_d.pop_front();
        void'(rq_t.pop_front());
      end else begin
        bus.i_pool_valid <= 2'b00;
      end
    end
  end

  // Monitor: logs writes and timing of key strobes.
  int          wr_cnt, done_cnt, rd_cnt, rd_bad, rd_first, busy_cnt, ps_cnt, ps_cyc, pv_first, last_wr;
  int          done_cyc [4];
  logic [1:0]  wr_addr_log [16];
  logic [63:0] wr_data_log [16];

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; rd_cnt = 0; rd_bad = 0; rd_first = -1;
    busy_cnt = 0; ps_cnt = 0; ps_cyc = -1; pv_first = -1; last_wr = -1;
    for (int i = 0; i < 4; i++) done_cyc[i] = -1;
  endtask

  always @(negedge clk) begin
    if (bus.o_wr_en) begin
      if (wr_cnt < 16) begin
        wr_addr_log[wr_cnt] = bus.o_wr_addr;
        wr_data_log[wr_cnt] = bus.o_wr_data;
      end
      wr_cnt++;
      last_wr = cyc;
    end
    if (bus.o_done) begin
      if (done_cnt < 4) done_cyc[done_cnt] = cyc;
      done_cnt++;
    end
    if (bus.o_rd_en) begin
      if (rd_first < 0) rd_first = cyc;
      if (bus.o_rd_addr != 4'(rd_cnt % 16)) rd_bad++;
      rd_cnt++;
    end
    if (bus.o_busy) busy_cnt++;
    if (bus.o_pool_start) begin
      ps_cnt++;
      ps_cyc = cyc;
    end
    if (bus.o_pool_valid && pv_first < 0) pv_first = cyc;
  end

  function automatic logic out_or();
    return |{bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_rd_addr, bus.o_pool_start,
             bus.o_pool_valid, bus.o_pool_data, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_err};
  endfunction

  task automatic wait_done(input int n);
    int budget;
    budget = 300;
    while (done_cnt < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("done_wait", done_cnt, n);
  endtask

  task automatic run_pass(input int delay, input int extra, output int start_c);
    model_delay = delay;
    model_extra = extra;
    clear_mon();
    bus.i_start = 1'b1;
    start_c = cyc;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_done(1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_l0 [4];
  logic [31:0] exp_l1 [4];

  task automatic check_writes(input string tag, input int base);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), wr_addr_log[base+i], i);
      chk($sformatf("%s_wr%0d_data", tag, i), wr_data_log[base+i], {exp_l1[i], exp_l0[i]});
    end
  endtask

  task automatic check_pass(input string tag, input int sc, input int exp_done, input int exp_last);
    chk({tag, "_wr_cnt"}, wr_cnt, 4);
    check_writes(tag, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_rel"}, done_cyc[0] - sc, exp_done);
    chk({tag, "_last_wr_rel"}, last_wr - sc, exp_last);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_done);
    chk({tag, "_rd_cnt"}, rd_cnt, 16);
    chk({tag, "_rd_addr_seq"}, rd_bad, 0);
    chk({tag, "_rd_first_rel"}, rd_first - sc, 1);
    chk({tag, "_pool_start"}, {ps_cnt[15:0], 16'(ps_cyc - sc)}, {16'd1, 16'd1});
    chk({tag, "_pool_valid_first"}, pv_first - sc, 3);
  endtask

  initial begin
    vec_t vecs [3];
    int   sc;
    int   budget;
    exp_l0 = '{32'd10, 32'd14, 32'd26, 32'd30};
    exp_l1 = '{32'd11, 32'd15, 32'd27, 32'd31};
    vecs[0] = '{0, 0, 21, 20};
    vecs[1] = '{20, 0, 41, 40};
    vecs[2] = '{0, 2, 21, 20};

    rst = 1'b1;
    bus.i_start = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_or(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", out_or(), 0);

    // Table-driven passes: nominal, delayed results, surplus results.
    for (int v = 0; v < 3; v++) begin
      run_pass(vecs[v].delay, vecs[v].extra, sc);
      check_pass($sformatf("vec%0d", v), sc, vecs[v].exp_done_rel, vecs[v].exp_last_wr_rel);
    end

    // i_start held high: one pass, then a restart right after DONE.
    model_delay = 0; model_extra = 0;
    clear_mon();
    bus.i_start = 1'b1;
    sc = cyc;
    wait_done(2);
    bus.i_start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("hold_done_cnt", done_cnt, 2);
    chk("hold_done1_rel", done_cyc[0] - sc, 21);
    chk("hold_done_gap", done_cyc[1] - done_cyc[0], 22);
    chk("hold_wr_cnt", wr_cnt, 8);
    check_writes("hold_p1", 0);
    check_writes("hold_p2", 4);
    chk("hold_rd_cnt", rd_cnt, 32);
    chk("hold_rd_seq", rd_bad, 0);
    chk("hold_pool_start_cnt", ps_cnt, 2);

    // Reset in the middle of the feed.
    clear_mon();
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    budget = 50;
    while (!(bus.o_rd_en && bus.o_rd_addr == 4'd7) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("rst_reach_addr7", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 4'd7});
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", out_or(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_write", wr_cnt, 0);
    run_pass(0, 0, sc);
    check_pass("rst_restart", sc, 21, 20);

    // Partial lane valid during a pass.
    model_delay = 0; model_extra = 0;
    clear_mon();
    bus.i_start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    force_partial = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lane_err_set", bus.o_err, EXP_ERR);
    wait_done(1);
    repeat (5) @(posedge clk);
    #1;
    chk("lane_err_sticky", bus.o_err, EXP_ERR);
    check_pass("lane", sc, 21, 20);
    clear_mon();
    bus.i_start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("lane_err_cleared", bus.o_err, 0);
    wait_done(1);
    repeat (5) @(posedge clk);
    #1;
    check_pass("after_lane", sc, 21, 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
